// File: rtl/cpu_reg_pkg.sv
// cpu_reg_pkg: shared types and constants for the CPU register bank.
//   reg_op_t    - register operation selected by the control unit
//   REG_*       - register indices of the 6502 bank (A, X, Y, S)
//   SRC_*       - write-data source indices (ALU result, memory read)
package cpu_reg_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_INC  = 2'd1,
    OP_DEC  = 2'd2,
    OP_HOLD = 2'd3
  } reg_op_t;

  localparam int REG_A = 0;
  localparam int REG_X = 1;
  localparam int REG_Y = 2;
  localparam int REG_S = 3;

  localparam int SRC_ALU = 0;
  localparam int SRC_MEM = 1;

endpackage

// File: rtl/reg_next_logic.sv
// reg_next_logic: combinational next-value computation for one register.
// Ports:
//   cur_val  in  WIDTH  current contents of the target register
//   src_val  in  WIDTH  already-selected write-source data
//   op       in  reg_op_t operation
//   next_val out WIDTH  value to commit
//   wrap     out 1      INC from all-ones or DEC from zero
module reg_next_logic
  import cpu_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] cur_val,
  input  logic [WIDTH-1:0] src_val,
  input  reg_op_t          op,
  output logic [WIDTH-1:0] next_val,
  output logic             wrap
);

  always_comb begin
    next_val = cur_val;
    wrap     = 1'b0;
    case (op)
      OP_LOAD: next_val = src_val;
      OP_INC: begin
        next_val = cur_val + WIDTH'(1);
        wrap     = &cur_val;
      end
      OP_DEC: begin
        next_val = cur_val - WIDTH'(1);
        wrap     = (cur_val == '0);
      end
      default: begin
        next_val = cur_val;
        wrap     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_reg_file.sv
// cpu_reg_file: NREG x WIDTH CPU register bank with selectable write source,
// in-place increment/decrement, two combinational read ports and registered
// Z/N/wrap status of the last committed write.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   cpu_en               clock enable; nothing changes while low
//   wd [NSRC*WIDTH]      write data, source k at [k*WIDTH +: WIDTH]
//   wd_src               write-source select (out of range -> source 0)
//   wr_idx, write, op    target register, write request, reg_op_t
//   rd_idx0/1, rd_data0/1 asynchronous read ports (out of range -> 0)
//   flag_z, flag_n, wrap status of the last committed value
module cpu_reg_file
  import cpu_reg_pkg::*;
#(
  parameter int               WIDTH  = 8,
  parameter int               NREG   = 4,
  parameter int               NSRC   = 2,
  parameter int               SP_IDX = 3,
  parameter logic [WIDTH-1:0] SP_RST = 8'hFD,
  localparam int              SW     = (NSRC > 1) ? $clog2(NSRC) : 1,
  localparam int              IW     = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_en,
  input  logic [NSRC*WIDTH-1:0] wd,
  input  logic [SW-1:0]         wd_src,
  input  logic [IW-1:0]         wr_idx,
  input  logic                  write,
  input  logic [1:0]            op,
  input  logic [IW-1:0]         rd_idx0,
  input  logic [IW-1:0]         rd_idx1,
  output logic [WIDTH-1:0]      rd_data0,
  output logic [WIDTH-1:0]      rd_data1,
  output logic                  flag_z,
  output logic                  flag_n,
  output logic                  wrap
);

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] cur_val;
  logic [WIDTH-1:0] src_val;
  logic [WIDTH-1:0] next_val;
  logic             next_wrap;
  logic             wr_in_range;
  logic             commit;
  reg_op_t          op_e;

  assign op_e = reg_op_t'(op);

  // Target register lookup; an index past NREG matches nothing, which
  // both blocks the commit and leaves cur_val at a harmless zero.
  always_comb begin
    cur_val     = '0;
    wr_in_range = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (wr_idx == IW'(i)) begin
        cur_val     = regs[i];
        wr_in_range = 1'b1;
      end
    end
  end

  // Source select: defaults to source 0 so an unused select code
  // falls back to the ALU result.
  always_comb begin
    src_val = wd[0 +: WIDTH];
    for (int k = 1; k < NSRC; k++) begin
      if (wd_src == SW'(k)) src_val = wd[k*WIDTH +: WIDTH];
    end
  end

  reg_next_logic #(.WIDTH(WIDTH)) u_next (
    .cur_val  (cur_val),
    .src_val  (src_val),
    .op       (op_e),
    .next_val (next_val),
    .wrap     (next_wrap)
  );

  assign commit = cpu_en & write & wr_in_range & (op_e != OP_HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      wrap   <= 1'b0;
    end else if (commit) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_idx == IW'(i)) regs[i] <= next_val;
      end
      flag_z <= (next_val == '0);
      flag_n <= next_val[WIDTH-1];
      wrap   <= next_wrap;
    end
  end

  // Read ports see stored state only: a read of the register being
  // written returns the old value until after the edge.
  always_comb begin
    rd_data0 = '0;
    rd_data1 = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd_idx0 == IW'(i)) rd_data0 = regs[i];
      if (rd_idx1 == IW'(i)) rd_data1 = regs[i];
    end
  end

endmodule

// File: doc/cpu_reg_file.md
Name: cpu_reg_file

Overview:
- Parametrised CPU register bank: NREG registers of WIDTH bits. For the 6502 core this is A, X, Y and S.
- Adds three things over the single-register block:
  - selectable write source (NSRC inputs);
  - in-place increment/decrement with wrap detection;
  - two asynchronous read ports and registered Z/N/wrap status of the last committed write.
- Sits between the ALU/memory read path and the CPU control unit. The whole bank is gated by cpu_en.

Parameters:
- WIDTH, 8, register width in bits.
- NREG, 4, number of registers (>=2).
- NSRC, 2, number of write-data sources (>=2; source 0 = ALU result, 1 = memory read).
- SP_IDX, 3, index of the stack-pointer register.
- SP_RST, 8'hFD, reset value of register SP_IDX. All other registers reset to 0.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cpu_en  in  1  CPU clock-enable; no state changes when 0
- wd  in  NSRC*WIDTH  write data; source k occupies bits [k*WIDTH +: WIDTH]
- wd_src  in  SW=max(1,$clog2(NSRC))  write-source select
- wr_idx  in  IW=max(1,$clog2(NREG))  target register
- write  in  1  write request
- op  in  2  reg_op_t: OP_LOAD=0, OP_INC=1, OP_DEC=2, OP_HOLD=3
- rd_idx0, rd_idx1  in  IW  read-port indices
- rd_data0, rd_data1  out  WIDTH  read data
- flag_z  out  1  last committed value == 0
- flag_n  out  1  MSB of last committed value
- wrap  out  1  last committed INC/DEC wrapped

Behaviour:
- Reset (reset_n=0, asynchronous):
  - register SP_IDX = SP_RST, all other registers = 0;
  - flag_z=0, flag_n=0, wrap=0.
  - Reset overrides everything, including mid-operation.
  - Deassertion takes effect at the next clk edge.
- Commit condition: cpu_en & write & (wr_idx < NREG) & (op != OP_HOLD).
  - Evaluated at posedge clk. Takes effect in one cycle; the new value is visible on the read ports after that edge.
- Next value on commit:
  - OP_LOAD: wd source wd_src. If wd_src >= NSRC, source 0 is used.
  - OP_INC: reg+1, modulo 2^WIDTH.
  - OP_DEC: reg-1, modulo 2^WIDTH.
- Wrap:
  - INC from all-ones gives 0 with wrap=1.
  - DEC from 0 gives all-ones with wrap=1.
  - LOAD always gives wrap=0.
- On commit: flag_z, flag_n and wrap are updated from the committed value in the same edge.
- No commit: all registers and flags hold. This covers cpu_en=0, write=0, OP_HOLD and out-of-range wr_idx.
- Read ports:
  - Purely combinational from current register state; no write bypass. A read of wr_idx in the commit cycle returns the old value.
  - rd_idx >= NREG returns 0.
  - Both ports may address the same register.
- Only one write per cycle. Register 0..NREG-1 contents are independent except through this port.
- Arithmetic is unsigned and WIDTH-bit. The carry is not exported beyond wrap.

Decomposition:
- Package cpu_reg_pkg contains:
  - reg_op_t enum (OP_LOAD, OP_INC, OP_DEC, OP_HOLD);
  - index constants REG_A=0, REG_X=1, REG_Y=2, REG_S=3;
  - SRC_ALU=0, SRC_MEM=1.
- One combinational sub-module, reg_next_logic. Inputs: current value, selected source data, op. Outputs: next value and wrap.
- cpu_reg_file holds the storage array, commit gating, flags and read muxes.

Test Plan:
- Reset: assert reset_n=0 with no clk edge.
  - Expect A=X=Y=0, S=8'hFD, flags 0, asynchronously.
  - Release, then check that nothing changes without commit.
- LOAD X from memory: wd_src=1, wd[15:8]=8'h80, wr_idx=1, op=LOAD, write=1, cpu_en=1.
  - Next cycle: rd_data0 (idx 1) = 8'h80, flag_n=1, flag_z=0, wrap=0.
  - In the write cycle itself, rd_data0 = 0 (no bypass).
- Wrap: load Y=8'hFF, then OP_INC on Y.
  - Expect Y=0, flag_z=1, wrap=1.
  - Then OP_DEC on Y: expect 8'hFF, flag_n=1, wrap=1.
  - Then LOAD 8'h01: expect wrap=0.
- Gating: with cpu_en=0, write=1, op=INC on S.
  - Expect S stays 8'hFD and flags unchanged.
  - Same result for op=HOLD with cpu_en=1.
- Mid-operation reset: pulse reset_n low between edges during a stream of DEC on S.
  - Expect S=8'hFD immediately, flags 0.
  - The DEC stream resumes correctly (S=8'hFC) on the first enabled edge after release.
- Dual read / out-of-range, with NREG=3 parameterisation:
  - rd_idx0=rd_idx1=2 returns identical data.
  - rd_idx=3 returns 0.
  - A write with wr_idx=3 changes no register or flag.
